// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and constants for the fetch and decode stages.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    localparam int OPCODE_W = 6;
    localparam int REG_W    = 5;
    localparam int SHAMT_W  = 5;
    localparam int FUNCT_W  = 6;
    localparam int IMM_W    = 16;
    localparam int JIDX_W   = 26;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

    // Signed word offset turned into a byte offset.
    function automatic logic signed [31:0] branch_byte_offset(input logic [IMM_W-1:0] imm);
        logic signed [31:0] ext;
        ext = {{(32-IMM_W){imm[IMM_W-1]}}, imm};
        return ext <<< 2;
    endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection for the fetch stage: jump over branch over stall over fault park.
module fetch_next_pc
    import mips_pkg::*;
(
    input  logic [31:0]       pc_q,
    input  logic [31:0]       pc4,
    input  logic              stall,
    input  logic              fetch_fault,
    input  logic              branch_taken,
    input  logic [IMM_W-1:0]  branch_imm,
    input  logic              jump_en,
    input  logic [JIDX_W-1:0] jump_idx,
    input  logic [31:0]       redirect_base,
    output logic [31:0]       next_pc,
    output logic              flush
);

    logic signed [31:0] branch_target;
    logic        [31:0] jump_target;

    assign branch_target = $signed(redirect_base) + branch_byte_offset(branch_imm);
    assign jump_target   = {redirect_base[31:28], jump_idx, 2'b00};

    always_comb begin
        next_pc = pc4;
        flush   = jump_en | branch_taken;
        if (jump_en) begin
            next_pc = jump_target;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end else if (stall || fetch_fault) begin
            next_pc = pc_q;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// MIPS IF stage: owns the PC, drives instruction memory and captures the IF/ID register.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MEM_SIZE = 256
) (
    input  logic              clk,
    input  logic              resetN,
    output logic [31:0]       PC,
    input  logic [31:0]       instruction,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [IMM_W-1:0]  branch_imm,
    input  logic              jump_en,
    input  logic [JIDX_W-1:0] jump_idx,
    input  logic [31:0]       redirect_base,
    output logic [31:0]       if_id_instr,
    output logic [31:0]       if_id_pc4,
    output logic              if_id_valid,
    output logic              fetch_fault,
    output logic [15:0]       fetch_count
);

    logic [31:0] pc_q;
    logic [31:0] pc4;
    logic [31:0] next_pc;
    logic        flush;
    if_id_t      if_id_p1;
    logic [15:0] count_q;

    assign pc4         = pc_q + PC_STEP;
    assign fetch_fault = (pc_q >= 32'(MEM_SIZE));

    fetch_next_pc u_next_pc (
        .pc_q          (pc_q),
        .pc4           (pc4),
        .stall         (stall),
        .fetch_fault   (fetch_fault),
        .branch_taken  (branch_taken),
        .branch_imm    (branch_imm),
        .jump_en       (jump_en),
        .jump_idx      (jump_idx),
        .redirect_base (redirect_base),
        .next_pc       (next_pc),
        .flush         (flush)
    );

    // ---- IF -> ID boundary ----
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pc_q     <= RESET_PC;
            if_id_p1 <= '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};
            count_q  <= 16'h0;
        end else begin
            pc_q <= next_pc;
            if (flush) begin
                if_id_p1 <= '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};
            end else if (stall) begin
                if_id_p1 <= if_id_p1;
            end else if (fetch_fault) begin
                if_id_p1 <= '{instr: NOP_INSTR, pc4: pc4, valid: 1'b0};
            end else begin
                if_id_p1 <= '{instr: instruction, pc4: pc4, valid: 1'b1};
                count_q  <= count_q + 16'd1;
            end
        end
    end

    assign PC          = pc_q;
    assign if_id_instr = if_id_p1.instr;
    assign if_id_pc4   = if_id_p1.pc4;
    assign if_id_valid = if_id_p1.valid;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus randomized traffic vs a reference model.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        resetN;
    logic [31:0] PC;
    logic [31:0] instruction;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_imm;
    logic        jump_en;
    logic [25:0] jump_idx;
    logic [31:0] redirect_base;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        fetch_fault;
    logic [15:0] fetch_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instruction_fetch #(.RESET_PC(32'h0), .MEM_SIZE(256)) dut (
        .clk           (clk),
        .resetN        (resetN),
        .PC            (PC),
        .instruction   (instruction),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_imm    (branch_imm),
        .jump_en       (jump_en),
        .jump_idx      (jump_idx),
        .redirect_base (redirect_base),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid),
        .fetch_fault   (fetch_fault),
        .fetch_count   (fetch_count)
    );

    // Instruction memory: 256 bytes = 64 words, read combinationally.
    logic [31:0] mem [0:63];
    assign instruction = (PC < 32'd256) ? mem[PC[7:2]] : 32'hDEAD_BEEF;

    // Reference model state
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid;
    logic [15:0] m_count;

    function automatic logic [113:0] dut_state();
        return {PC, if_id_instr, if_id_pc4, if_id_valid, fetch_fault, fetch_count};
    endfunction

    function automatic logic [113:0] exp_state();
        return {m_pc, m_instr, m_pc4, m_valid, (m_pc >= 32'd256), m_count};
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_count = 16'h0;
    endtask

    task automatic idle_inputs();
        stall = 0; branch_taken = 0; branch_imm = 0; jump_en = 0; jump_idx = 0; redirect_base = 0;
    endtask

    // Advance the model from the current inputs, then clock the DUT and settle.
    task automatic step();
        logic [31:0] npc;
        logic        flt;
        int          off;
        flt = (m_pc >= 32'd256);
        off = int'($signed(branch_imm));
        if (jump_en)           npc = {redirect_base[31:28], jump_idx, 2'b00};
        else if (branch_taken) npc = redirect_base + 32'(off * 4);
        else if (stall || flt) npc = m_pc;
        else                   npc = m_pc + 32'd4;
        if (jump_en || branch_taken) begin
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (stall) begin
            // IF/ID keeps its contents
        end else if (flt) begin
            m_instr = 32'h0; m_pc4 = m_pc + 32'd4; m_valid = 1'b0;
        end else begin
            m_instr = mem[m_pc[7:2]]; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
            m_count = m_count + 16'd1;
        end
        m_pc = npc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        checks++;
        if (dut_state() !== exp_state()) begin
            errors++; $display("FAIL reset_state: got %h expected %h", dut_state(), exp_state());
        end
        checks++;
        if (PC !== 32'h0 || if_id_valid !== 1'b0 || fetch_count !== 16'h0) begin
            errors++; $display("FAIL reset_regs: PC=%h valid=%b count=%h expected 0/0/0", PC, if_id_valid, fetch_count);
        end
        @(negedge clk);
        resetN = 1'b1;
    endtask

    task automatic test_sequential();
        step();
        checks++;
        if (PC !== 32'h4 || if_id_instr !== 32'h20110001 || if_id_pc4 !== 32'h4 || if_id_valid !== 1'b1) begin
            errors++; $display("FAIL seq_first: PC=%h instr=%h pc4=%h valid=%b expected 4/20110001/4/1", PC, if_id_instr, if_id_pc4, if_id_valid);
        end
        step();
        checks++;
        if (PC !== 32'h8 || if_id_instr !== 32'h2012000A || if_id_pc4 !== 32'h8 || fetch_count !== 16'd2) begin
            errors++; $display("FAIL seq_second: PC=%h instr=%h pc4=%h count=%0d expected 8/2012000a/8/2", PC, if_id_instr, if_id_pc4, fetch_count);
        end
        checks++;
        if (dut_state() !== exp_state()) begin
            errors++; $display("FAIL seq_model: got %h expected %h", dut_state(), exp_state());
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (PC !== 32'h8 || if_id_instr !== 32'h2012000A || if_id_pc4 !== 32'h8 || fetch_count !== 16'd2) begin
                errors++; $display("FAIL stall_hold%0d: PC=%h instr=%h pc4=%h count=%0d expected 8/2012000a/8/2", i, PC, if_id_instr, if_id_pc4, fetch_count);
            end
        end
        stall = 1'b0;
        step();
        checks++;
        if (PC !== 32'hC || if_id_instr !== 32'h02329820 || fetch_count !== 16'd3) begin
            errors++; $display("FAIL stall_resume: PC=%h instr=%h count=%0d expected c/02329820/3", PC, if_id_instr, fetch_count);
        end
    endtask

    task automatic test_branch();
        branch_taken = 1'b1; redirect_base = 32'h8; branch_imm = 16'hFFFE;
        step();
        checks++;
        if (PC !== 32'h0 || if_id_valid !== 1'b0 || if_id_pc4 !== 32'h0) begin
            errors++; $display("FAIL branch_back: PC=%h valid=%b pc4=%h expected 0/0/0", PC, if_id_valid, if_id_pc4);
        end
        idle_inputs();
        step();
        branch_taken = 1'b1; redirect_base = 32'h8; branch_imm = 16'hFFFE; stall = 1'b1;
        step();
        checks++;
        if (PC !== 32'h0 || if_id_valid !== 1'b0) begin
            errors++; $display("FAIL branch_over_stall: PC=%h valid=%b expected 0/0", PC, if_id_valid);
        end
        checks++;
        if (dut_state() !== exp_state()) begin
            errors++; $display("FAIL branch_model: got %h expected %h", dut_state(), exp_state());
        end
        idle_inputs();
    endtask

    task automatic test_jump_priority();
        jump_en = 1'b1; branch_taken = 1'b1; redirect_base = 32'h10; jump_idx = 26'h10; branch_imm = 16'h0004;
        step();
        checks++;
        if (PC !== 32'h40 || if_id_valid !== 1'b0) begin
            errors++; $display("FAIL jump_wins: PC=%h valid=%b expected 40/0", PC, if_id_valid);
        end
        idle_inputs();
    endtask

    task automatic test_fault();
        jump_en = 1'b1; jump_idx = 26'h3C;
        step();
        idle_inputs();
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (PC !== 32'h100 || fetch_fault !== 1'b1) begin
            errors++; $display("FAIL fault_reach: PC=%h fault=%b expected 100/1", PC, fetch_fault);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (PC !== 32'h100 || fetch_fault !== 1'b1 || if_id_valid !== 1'b0 || if_id_pc4 !== 32'h104) begin
                errors++; $display("FAIL fault_park%0d: PC=%h fault=%b valid=%b pc4=%h expected 100/1/0/104", i, PC, fetch_fault, if_id_valid, if_id_pc4);
            end
        end
        checks++;
        if (dut_state() !== exp_state()) begin
            errors++; $display("FAIL fault_model: got %h expected %h", dut_state(), exp_state());
        end
        jump_en = 1'b1; jump_idx = 26'h0; redirect_base = 32'h104;
        step();
        checks++;
        if (PC !== 32'h0 || fetch_fault !== 1'b0) begin
            errors++; $display("FAIL fault_clear: PC=%h fault=%b expected 0/0", PC, fetch_fault);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            stall         = ($urandom_range(0, 9) < 2);
            branch_taken  = ($urandom_range(0, 9) == 0);
            jump_en       = ($urandom_range(0, 19) == 0);
            branch_imm    = 16'($signed($urandom_range(0, 16)) - 8);
            jump_idx      = 26'($urandom_range(0, 70));
            redirect_base = 32'($urandom_range(0, 300)) & 32'hFFFF_FFFC;
            step();
            checks++;
            if (dut_state() !== exp_state()) begin
                errors++; $display("FAIL random_cycle%0d: got %h expected %h", i, dut_state(), exp_state());
            end
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        jump_en = 1'b1; jump_idx = 26'h10; redirect_base = 32'h0;
        step();
        idle_inputs();
        stall = 1'b1;
        step();
        checks++;
        if (PC !== 32'h40) begin
            errors++; $display("FAIL areset_setup: PC=%h expected 40", PC);
        end
        #2;
        resetN = 1'b0;
        jump_en = 1'b1;
        model_reset();
        #1;
        checks++;
        if (dut_state() !== exp_state()) begin
            errors++; $display("FAIL areset_async: got %h expected %h", dut_state(), exp_state());
        end
        @(posedge clk);
        #1;
        checks++;
        if (dut_state() !== exp_state()) begin
            errors++; $display("FAIL areset_held: got %h expected %h", dut_state(), exp_state());
        end
        @(negedge clk);
        idle_inputs();
        resetN = 1'b1;
        step();
        checks++;
        if (PC !== 32'h4 || if_id_instr !== 32'h20110001 || if_id_valid !== 1'b1 || fetch_count !== 16'd1) begin
            errors++; $display("FAIL areset_resume: PC=%h instr=%h valid=%b count=%0d expected 4/20110001/1/1", PC, if_id_instr, if_id_valid, fetch_count);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h20110001;
        mem[1] = 32'h2012000A;
        mem[2] = 32'h02329820;
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_jump_priority();
        test_fault();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
